// File: rtl/correlation_stream.sv
// 10-tap fixed-coefficient correlator (h_k = k+1) over an unsigned 4-bit sample stream.
// Latency: y_valid rises 10 edges after the accept that leaves the window full.
// Backpressure: s_ready is low while accumulating or holding; y is held until y_ready.
module correlation_stream #(
  parameter int DATA_W = 4,
  parameter int Y_W    = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [Y_W-1:0]    y,
  output logic              busy
);

  localparam int TAPS   = 10;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] win [TAPS];   // win[0] newest, win[TAPS-1] oldest
  logic [3:0]        fill;         // saturates at TAPS
  logic [3:0]        k;            // tap index while accumulating
  logic [Y_W-1:0]    acc;

  logic [DATA_W-1:0] tap;
  logic [DATA_W-1:0] coef;
  logic [PROD_W-1:0] term;
  logic [Y_W-1:0]    sum;
  logic [3:0]        fill_nxt;

  // Select the window entry addressed by the tap index for the shared multiply-add.
  always_comb begin
    tap = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (k == 4'(i)) tap = win[i];
    end
  end

  // Coefficient k+1 never exceeds 10, so it fits in the sample width.
  assign coef     = DATA_W'(k) + DATA_W'(1);
  assign term     = PROD_W'(tap) * PROD_W'(coef);
  assign sum      = acc + Y_W'(term);
  assign fill_nxt = (fill == 4'(TAPS)) ? fill : fill + 4'd1;

  // Sequencer, window and registered handshake outputs; flush outranks accept and handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
      fill    <= '0;
      k       <= '0;
      acc     <= '0;
      y       <= '0;
      s_ready <= 1'b0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
    end else if (flush) begin
      // y is deliberately left alone so the last result stays observable.
      state   <= IDLE;
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
      fill    <= '0;
      k       <= '0;
      acc     <= '0;
      s_ready <= 1'b1;
      y_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Also arms s_ready on the first edge after reset release.
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            win[0] <= s_data;
            for (int i = 1; i < TAPS; i++) win[i] <= win[i-1];
            fill <= fill_nxt;
            if (fill_nxt == 4'(TAPS)) begin
              state   <= ACC;
              k       <= '0;
              acc     <= '0;
              s_ready <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        ACC: begin
          acc <= sum;
          if (k == 4'(TAPS - 1)) begin
            y       <= sum;
            k       <= '0;
            state   <= HOLD;
            y_valid <= 1'b1;
          end else begin
            k <= k + 4'd1;
          end
        end
        HOLD: begin
          if (y_ready) begin
            state   <= IDLE;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          y_valid <= 1'b0;
          busy    <= 1'b0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_correlation_stream.sv
// Bench for correlation_stream: scenario tasks against a window/queue reference model.
// Latency: checks the 10-edge result latency on every produced result.
// Backpressure: exercises y_ready stalls, flush in HOLD and reset mid-accumulation.
module tb_correlation_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic        y_valid;
  logic        y_ready;
  logic [11:0] y;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: most recent samples first, at most 10, plus a saturating fill count.
  int m_win[$];
  int m_fill;

  correlation_stream #(.DATA_W(4), .Y_W(12)) dut (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y       (y),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    m_win.delete();
    m_fill = 0;
  endfunction

  function automatic void model_push(input int d);
    m_win.push_front(d);
    if (m_win.size() > 10) void'(m_win.pop_back());
    if (m_fill < 10) m_fill++;
  endfunction

  function automatic int model_y();
    int s = 0;
    foreach (m_win[i]) s += (i + 1) * m_win[i];
    return s;
  endfunction

  // Offer one sample; if it completes a full window, check the result and finish it.
  // rdy_delay >= 0: stall that many HOLD cycles (with s_valid junk) then handshake.
  // rdy_delay < 0 : y_ready is already tied high by the caller.
  // flush_hold   : end HOLD with flush+y_ready instead of a plain handshake.
  task automatic send(input logic [3:0] d, input int rdy_delay, input bit flush_hold);
    int n;
    int exp_y;
    n = 0;
    while (!s_ready && n < 50) begin @(posedge clock); #1; n++; end
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("FAIL send_ready: s_ready=%b required 1", s_ready); end
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clock); #1;
    s_valid = 1'b0;
    s_data  = 4'($urandom);
    model_push(int'(d));
    if (m_fill == 10) begin
      exp_y = model_y();
      n = 0;
      while (!y_valid && n < 30) begin @(posedge clock); #1; n++; end
      compared++;
      if (n !== 10) begin mismatched++; $display("FAIL latency: %0d edges, required 10", n); end
      compared++;
      if (y !== 12'(exp_y)) begin mismatched++; $display("FAIL y_value: y=%0d required %0d", y, exp_y); end
      compared++;
      if (busy !== 1'b1 || s_ready !== 1'b0) begin
        mismatched++; $display("FAIL hold_flags: busy=%b s_ready=%b required 1/0", busy, s_ready);
      end
      if (flush_hold) begin
        flush = 1'b1; y_ready = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; y_ready = 1'b0;
        model_clear();
        compared++;
        if (y_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
          mismatched++; $display("FAIL flush_hold: y_valid=%b busy=%b s_ready=%b required 0/0/1", y_valid, busy, s_ready);
        end
        compared++;
        if (y !== 12'(exp_y)) begin mismatched++; $display("FAIL flush_keep_y: y=%0d required %0d", y, exp_y); end
      end else if (rdy_delay >= 0) begin
        for (int c = 0; c < rdy_delay; c++) begin
          s_valid = 1'b1;
          s_data  = 4'($urandom);
          @(posedge clock); #1;
          compared++;
          if (y_valid !== 1'b1 || y !== 12'(exp_y) || s_ready !== 1'b0) begin
            mismatched++; $display("FAIL stall: y_valid=%b y=%0d s_ready=%b required 1/%0d/0", y_valid, y, s_ready, exp_y);
          end
        end
        y_ready = 1'b1;
        @(posedge clock); #1;
        y_ready = 1'b0;
        s_valid = 1'b0;
        compared++;
        if (y_valid !== 1'b0 || s_ready !== 1'b1) begin
          mismatched++; $display("FAIL handshake: y_valid=%b s_ready=%b required 0/1", y_valid, s_ready);
        end
      end else begin
        @(posedge clock); #1;
        compared++;
        if (y_valid !== 1'b0) begin mismatched++; $display("FAIL handshake_tied: y_valid=%b required 0", y_valid); end
      end
    end else begin
      @(posedge clock); #1;
      compared++;
      if (busy !== 1'b0 || y_valid !== 1'b0) begin
        mismatched++; $display("FAIL no_result: busy=%b y_valid=%b required 0/0", busy, y_valid);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 4'd0; y_ready = 1'b0;
    model_clear();
    #1;
    compared++;
    if (s_ready !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b0 || y !== 12'd0) begin
      mismatched++; $display("FAIL reset_outputs: s_ready=%b y_valid=%b busy=%b y=%0d required all 0", s_ready, y_valid, busy, y);
    end
    #21 reset = 1'b1;
    #1;
    compared++;
    if (s_ready !== 1'b0) begin mismatched++; $display("FAIL ready_before_edge: s_ready=%b required 0", s_ready); end
    @(posedge clock); #1;
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("FAIL ready_after_edge: s_ready=%b required 1", s_ready); end
  endtask

  task automatic test_fill_ones();
    for (int i = 0; i < 9; i++) send(4'd1, 0, 1'b0);
    send(4'd1, 0, 1'b0);
    compared++;
    if (y !== 12'd55) begin mismatched++; $display("FAIL ones_y: y=%0d required 55", y); end
  endtask

  task automatic test_max();
    for (int i = 0; i < 10; i++) send(4'd15, 1, 1'b0);
    compared++;
    if (y !== 12'h339) begin mismatched++; $display("FAIL max_y: y=%0d required 825", y); end
  endtask

  task automatic test_impulse();
    y_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(4'd0, -1, 1'b0);
    compared++;
    if (y !== 12'd0) begin mismatched++; $display("FAIL zeros_y: y=%0d required 0", y); end
    send(4'd1, -1, 1'b0);
    compared++;
    if (y !== 12'd1) begin mismatched++; $display("FAIL impulse_0: y=%0d required 1", y); end
    for (int i = 0; i < 9; i++) begin
      send(4'd0, -1, 1'b0);
      compared++;
      if (y !== 12'(i + 2)) begin mismatched++; $display("FAIL impulse_%0d: y=%0d required %0d", i + 1, y, i + 2); end
    end
    y_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) send(4'($urandom), 5, 1'b0);
  endtask

  task automatic test_reset_mid_acc();
    s_valid = 1'b1; s_data = 4'd7;
    @(posedge clock); #1;
    s_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    compared++;
    if (s_ready !== 1'b0 || y_valid !== 1'b0 || busy !== 1'b0 || y !== 12'd0) begin
      mismatched++; $display("FAIL reset_acc: s_ready=%b y_valid=%b busy=%b y=%0d required all 0", s_ready, y_valid, busy, y);
    end
    #2 reset = 1'b1;
    model_clear();
    for (int i = 0; i < 10; i++) send(4'd2, 0, 1'b0);
    compared++;
    if (y !== 12'd110) begin mismatched++; $display("FAIL reset_refill_y: y=%0d required 110", y); end
  endtask

  task automatic test_flush_hold();
    send(4'($urandom), 0, 1'b1);
    for (int i = 0; i < 10; i++) send(4'($urandom), 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1; s_valid = 1'b1; s_data = 4'($urandom);
        @(posedge clock); #1;
        flush = 1'b0; s_valid = 1'b0;
        model_clear();
        compared++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
          mismatched++; $display("FAIL flush_idle: busy=%b s_ready=%b required 0/1", busy, s_ready);
        end
      end
      send(4'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_fill_ones();
    test_max();
    test_impulse();
    test_backpressure();
    test_reset_mid_acc();
    test_flush_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
